// File: rtl/regfile_wb_ctrl_if.sv
// Write-back controller bus: ALU/load write-back requests, decode claim/hazard
// signals and the registered register-bank write port.
interface regfile_wb_ctrl_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            we;
  logic [4:0]      ain;
  logic [XLEN-1:0] din;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           issue_valid, issue_rd, rs1, rs2,
    input  alu_ready, mem_ready, issue_ready, rs1_busy, rs2_busy, we, ain, din
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           issue_valid, issue_rd, rs1, rs2,
    output alu_ready, mem_ready, issue_ready, rs1_busy, rs2_busy, we, ain, din
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Write-back arbiter + destination scoreboard for the 32x32 register bank.
// Optional WB_ROUND_ROBIN_EN selects round-robin instead of load-over-ALU priority.
module regfile_wb_ctrl #(
  parameter int XLEN = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  regfile_wb_ctrl_if.slave bus
);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  wb_req_t         alu_req, mem_req, win_req;
  logic            alu_gnt, mem_gnt, hs, contend;
  logic            issue_rdy;
  logic            we_q, we_d;
  logic [4:0]      ain_q, ain_d;
  logic [XLEN-1:0] din_q, din_d;
  logic [31:0]     busy_q, busy_d;

  assign alu_req = '{rd: bus.alu_rd, data: bus.alu_data};
  assign mem_req = '{rd: bus.mem_rd, data: bus.mem_data};
  assign contend = bus.alu_valid & bus.mem_valid;

`ifdef WB_ROUND_ROBIN_EN
  logic rr_q;  // 0: ALU wins the next contended cycle, 1: load wins

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     rr_q <= 1'b0;
    else if (contend) rr_q <= ~rr_q;
  end

  assign alu_gnt = bus.alu_valid & ~(contend & rr_q);
  assign mem_gnt = bus.mem_valid & ~(contend & ~rr_q);
`else
  assign mem_gnt = bus.mem_valid;
  assign alu_gnt = bus.alu_valid & ~bus.mem_valid;
`endif

  assign hs        = alu_gnt | mem_gnt;
  assign win_req   = mem_gnt ? mem_req : alu_req;
  assign issue_rdy = ~busy_q[bus.issue_rd];

  always_comb begin
    we_d  = hs && (win_req.rd != 5'd0);
    ain_d = ain_q;
    din_d = din_q;
    if (hs) begin
      ain_d = win_req.rd;
      din_d = win_req.data;
    end
  end

  // Clear tracks the bank commit; a same-edge claim of that register must win.
  always_comb begin
    busy_d = busy_q;
    if (we_q) busy_d[ain_q] = 1'b0;
    if (bus.issue_valid && issue_rdy && bus.issue_rd != 5'd0)
      busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_q   <= 1'b0;
      ain_q  <= '0;
      din_q  <= '0;
      busy_q <= '0;
    end else begin
      we_q   <= we_d;
      ain_q  <= ain_d;
      din_q  <= din_d;
      busy_q <= busy_d;
    end
  end

  assign bus.alu_ready   = alu_gnt;
  assign bus.mem_ready   = mem_gnt;
  assign bus.issue_ready = issue_rdy;
  assign bus.rs1_busy    = busy_q[bus.rs1];
  assign bus.rs2_busy    = busy_q[bus.rs2];
  assign bus.we          = we_q;
  assign bus.ain         = ain_q;
  assign bus.din         = din_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: directed test-plan cases plus random
// write-back/issue traffic checked against a claim-set reference model.
module tb_regfile_wb_ctrl;
  localparam int XLEN = 32;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  regfile_wb_ctrl_if #(.XLEN(XLEN)) bus ();
  regfile_wb_ctrl #(.XLEN(XLEN)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic        we;
    logic [4:0]  ain;
    logic [31:0] din;
  } wr_t;

  int  checks = 0;
  int  passed = 0;
  wr_t exp_q[$];

  // Reference model: set of claimed registers, the write the bank sees this
  // cycle, the last written address/data, and whose turn it is under contention.
  bit          claimed[32];
  bit          commit_v;
  int          commit_rd;
  logic [4:0]  last_ain;
  logic [31:0] last_din;
  bit          alu_turn;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: the bank port after each edge must match the queued prediction.
  initial forever begin
    @(posedge clock);
    #2;
    if (reset_n && exp_q.size() > 0) begin
      wr_t e;
      e = exp_q.pop_front();
      chk("we",  32'(bus.we),  32'(e.we));
      chk("ain", 32'(bus.ain), 32'(e.ain));
      chk("din", bus.din, e.din);
    end
  end

  task automatic idle_inputs();
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
    bus.issue_valid = 0; bus.issue_rd = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    bus.rs1 = 5'd5; bus.rs2 = 5'd6;
    exp_q.delete();
    foreach (claimed[i]) claimed[i] = 0;
    commit_v = 0; commit_rd = 0; last_ain = 0; last_din = 0; alu_turn = 1;
    #2;
    chk("rst_we", 32'(bus.we), 0);
    chk("rst_ain", 32'(bus.ain), 0);
    chk("rst_din", bus.din, 0);
    chk("rst_rs1_busy", 32'(bus.rs1_busy), 0);
    chk("rst_rs2_busy", 32'(bus.rs2_busy), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_we", 32'(bus.we), 0);
    chk("post_rst_ain", 32'(bus.ain), 0);
    chk("post_rst_rs1_busy", 32'(bus.rs1_busy), 0);
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] r1, input logic [4:0] r2,
                       output logic ag, output logic mg);
    bit ir;
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = md;
    bus.issue_valid = iv; bus.issue_rd = ird;
    bus.rs1 = r1; bus.rs2 = r2;
    @(negedge clock);
    if (av && mv) begin
`ifdef WB_ROUND_ROBIN_EN
      ag = alu_turn; mg = !alu_turn;
      alu_turn = !alu_turn;
`else
      ag = 0; mg = 1;
`endif
    end else begin
      ag = av; mg = mv;
    end
    ir = !claimed[ird];
    chk("alu_ready", 32'(bus.alu_ready), 32'(ag));
    chk("mem_ready", 32'(bus.mem_ready), 32'(mg));
    chk("issue_ready", 32'(bus.issue_ready), 32'(ir));
    chk("rs1_busy", 32'(bus.rs1_busy), 32'(claimed[r1]));
    chk("rs2_busy", 32'(bus.rs2_busy), 32'(claimed[r2]));
    // Edge effects: commit releases its claim, then a new claim is recorded.
    if (commit_v) claimed[commit_rd] = 0;
    if (iv && ir && ird != 0) claimed[ird] = 1;
    if (ag || mg) begin
      last_ain = mg ? mrd : ard;
      last_din = mg ? md : ad;
      commit_v = (last_ain != 0);
      commit_rd = last_ain;
      exp_q.push_back('{we: commit_v, ain: last_ain, din: last_din});
    end else begin
      commit_v = 0;
      exp_q.push_back('{we: 1'b0, ain: last_ain, din: last_din});
    end
    @(posedge clock); #1;
  endtask

  initial begin
    logic ag, mg, av, mv;
    logic [4:0] ard, mrd;
    logic [31:0] ad, md;
    int alu_wins;
    #1;
    do_reset();

    // Single ALU write to x5 after a claim.
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 0, ag, mg);
    cycle(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5'd5, 0, ag, mg);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 0, ag, mg);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 0, ag, mg);

    // Reset while a write is being presented to the bank.
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd6, 0, 0, ag, mg);
    cycle(1, 5'd6, 32'h600D_0006, 0, 0, 0, 0, 0, 0, 5'd6, ag, mg);
    chk("we_before_rst", 32'(bus.we), 1);
    do_reset();

    // Contention for 4 cycles.
    alu_wins = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 5'd3, 32'hA000_0003, 1, 5'd4, 32'hB000_0004, 0, 0, 5'd3, 5'd4, ag, mg);
      if (ag) alu_wins++;
    end
`ifdef WB_ROUND_ROBIN_EN
    chk("contend_alu_wins", 32'(alu_wins), 2);
`else
    chk("contend_alu_wins", 32'(alu_wins), 0);
`endif

    // x0 write and x0 claim.
    cycle(0, 0, 0, 1, 5'd0, 32'h1234, 1, 5'd0, 5'd0, 0, ag, mg);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 0, ag, mg);

    // WAW stall on x7.
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0, ag, mg);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0, ag, mg);
    cycle(1, 5'd7, 32'h7777, 0, 0, 0, 1, 5'd7, 5'd7, 0, ag, mg);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0, ag, mg);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0, ag, mg);

    // Unclaimed write to x9, re-claimed on its commit cycle: stays busy.
    cycle(1, 5'd9, 32'h9999, 0, 0, 0, 0, 0, 5'd9, 0, ag, mg);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 0, ag, mg);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0, ag, mg);
    chk("x9_still_busy", 32'(bus.rs1_busy), 1);

    // Random traffic; losers hold their request until granted.
    av = 0; mv = 0; ard = 0; mrd = 0; ad = 0; md = 0;
    for (int n = 0; n < 400; n++) begin
      if (!av && $urandom_range(0, 2) != 0) begin
        av = 1; ard = 5'($urandom_range(0, 7)); ad = $urandom;
      end
      if (!mv && $urandom_range(0, 2) != 0) begin
        mv = 1; mrd = 5'($urandom_range(0, 7)); md = $urandom;
      end
      cycle(av, ard, ad, mv, mrd, md, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), ag, mg);
      if (ag) av = 0;
      if (mg) mv = 0;
    end

    idle_inputs();
    #5;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
